vga_text_renderer: RTL and testbench

- Text-mode VGA scan-out engine, directly downstream of memController's VGA read port.
- Generates 640x480@60 timing from ext_clk (50 MHz, pixel tick every 2nd clock).
- Fetches character words from text memory (0x0000, 128-word row stride) and glyph rows from glyph memory (0x2000, 8x8 glyphs, 4 words per glyph).
- Serialises glyph rows to RGB332 pixels; visible grid is 80 columns x 60 rows.

---
 rtl/vga_text_pkg.sv | 37 +++
 rtl/vga_timing_gen.sv | 82 ++++++++
 rtl/vga_text_renderer.sv | 173 +++++++++++++++++
 tb/tb_vga_text_renderer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants and helpers for the text-mode VGA renderer:
// timing defaults, memory map, text-word layout and the glyph address helper.
package vga_text_pkg;

   // 640x480@60 timing, in pixels and lines
   localparam int H_VIS = 640;
   localparam int H_FP  = 16;
   localparam int H_SW  = 96;
   localparam int H_BP  = 48;
   localparam int V_VIS = 480;
   localparam int V_FP  = 10;
   localparam int V_SW  = 2;
   localparam int V_BP  = 33;

   // Memory map
   localparam logic [14:0] GLYPH_BASE  = 15'h2000;
   localparam int          TEXT_STRIDE = 128;
   localparam int          ADDR_W      = 15;
   localparam int          DATA_W      = 16;

   // Text word: [7:0] char code, [15:8] foreground RGB332
   localparam int CHAR_LSB = 0;
   localparam int ATTR_LSB = 8;
   localparam int RGB_W    = 8;

   typedef struct packed {
      logic [RGB_W-1:0] attr;
      logic [7:0]       code;
   } text_word_t;

   // 8x8 glyphs stored as four 16-bit words; each word holds two pixel rows
   function automatic logic [ADDR_W-1:0] glyph_addr(input logic [7:0] code,
                                                    input logic [1:0] row_pair);
      return GLYPH_BASE + {5'd0, code, row_pair};
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Scan timing for the text renderer: pixel phase, h/v counters, registered
// active-low syncs and the frame_start pulse. Counter state is exported so the
// top level can register its colour output from the very same state.
module vga_timing_gen #(
   parameter int H_VIS = vga_text_pkg::H_VIS,
   parameter int H_FP  = vga_text_pkg::H_FP,
   parameter int H_SW  = vga_text_pkg::H_SW,
   parameter int H_BP  = vga_text_pkg::H_BP,
   parameter int V_VIS = vga_text_pkg::V_VIS,
   parameter int V_FP  = vga_text_pkg::V_FP,
   parameter int V_SW  = vga_text_pkg::V_SW,
   parameter int V_BP  = vga_text_pkg::V_BP
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       p,
   output logic [9:0] h,
   output logic [9:0] v,
   output logic       visible,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
   localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SW - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SW - 1);

   logic frame_tick;

   assign visible    = (h < H_VIS_L) && (v < V_VIS_L);
   assign frame_tick = (h == 10'd0) && (v == 10'd0) && !p;

   // Pixel phase toggles every clock; h/v advance on the second clock of a pixel
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p <= 1'b0;
         h <= 10'd0;
         v <= 10'd0;
      end else if (!enable) begin
         p <= 1'b0;
         h <= 10'd0;
         v <= 10'd0;
      end else begin
         p <= ~p;
         if (p) begin
            if (h == H_LAST) begin
               h <= 10'd0;
               v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
               h <= h + 10'd1;
            end
         end
      end
   end

   // Syncs and frame pulse registered from the current counter state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else if (!enable) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         hsync       <= !((h >= HS_FIRST) && (h <= HS_LAST));
         vsync       <= !((v >= VS_FIRST) && (v <= VS_LAST));
         frame_start <= frame_tick;
      end
   end

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode VGA scan-out: 80x60 cells of 8x8 glyphs at 640x480@60 from a
// 50 MHz clock. Each cell is fetched in the 16-clock window before it is shown
// (text word, then glyph row) and serialised MSB-first to RGB332.
// Optional blinking cursor: define VGA_TEXT_CURSOR_EN.
module vga_text_renderer #(
   parameter int H_VIS = vga_text_pkg::H_VIS,
   parameter int H_FP  = vga_text_pkg::H_FP,
   parameter int H_SW  = vga_text_pkg::H_SW,
   parameter int H_BP  = vga_text_pkg::H_BP,
   parameter int V_VIS = vga_text_pkg::V_VIS,
   parameter int V_FP  = vga_text_pkg::V_FP,
   parameter int V_SW  = vga_text_pkg::V_SW,
   parameter int V_BP  = vga_text_pkg::V_BP
) (
   input  logic        ext_clk,
   input  logic        reset,
   input  logic        enable,
   output logic [14:0] vga_addr,
   input  logic [15:0] vga_data_in,
   output logic        hsync,
   output logic        vsync,
   output logic [7:0]  rgb,
   output logic        frame_start
`ifdef VGA_TEXT_CURSOR_EN
   ,
   input  logic [6:0]  cursor_col,
   input  logic [5:0]  cursor_row
`endif
);

   import vga_text_pkg::*;

   localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
   localparam logic [9:0] H_FETCH_END = 10'(H_VIS - 8);
   localparam logic [9:0] H_PREFETCH  = 10'(H_TOTAL - 8);
   localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_VIS_L     = 10'(V_VIS);

   logic       p;
   logic [9:0] h;
   logic [9:0] v;
   logic       visible;

   vga_timing_gen #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
   ) u_timing (
      .clk        (ext_clk),
      .reset      (reset),
      .enable     (enable),
      .p          (p),
      .h          (h),
      .v          (v),
      .visible    (visible),
      .hsync      (hsync),
      .vsync      (vsync),
      .frame_start(frame_start)
   );

   logic [3:0]       sub;
   logic [9:0]       tgt_line;
   logic [6:0]       tgt_col;
   logic             fetch_on;
   logic [14:0]      text_addr;
   text_word_t       word;
   logic [7:0]       code;
   logic [RGB_W-1:0] attr;
   logic [15:0]      glyph;
   logic [7:0]       shift;
   logic [RGB_W-1:0] fg;
   logic             pix_bit;

   assign sub       = {h[2:0], p};
   assign word      = vga_data_in;
   assign text_addr = 15'(tgt_line[9:3]) * 15'(TEXT_STRIDE) + 15'(tgt_col);

   // Which cell the current 16-clock window prefetches, and whether it is shown at all
   always_comb begin
      tgt_line = v;
      tgt_col  = h[9:3] + 7'd1;
      fetch_on = 1'b0;
      if (h < H_FETCH_END) begin
         fetch_on = (v < V_VIS_L);
      end else if (h >= H_PREFETCH) begin
         tgt_col  = 7'd0;
         tgt_line = (v == V_LAST) ? 10'd0 : v + 10'd1;
         fetch_on = (tgt_line < V_VIS_L);
      end
   end

   // Fetch sequencer and pixel shifter; hand-off happens on the cell boundary
   always_ff @(posedge ext_clk or negedge reset) begin
      if (!reset) begin
         vga_addr <= 15'd0;
         code     <= 8'd0;
         attr     <= '0;
         glyph    <= 16'd0;
         shift    <= 8'd0;
         fg       <= '0;
      end else if (!enable) begin
         vga_addr <= 15'd0;
         code     <= 8'd0;
         attr     <= '0;
         glyph    <= 16'd0;
         shift    <= 8'd0;
         fg       <= '0;
      end else begin
         if (fetch_on) begin
            case (sub)
               4'd0: vga_addr <= text_addr;
               4'd2: begin
                  code <= word.code;
                  attr <= word.attr;
               end
               4'd3: vga_addr <= glyph_addr(code, tgt_line[2:1]);
               4'd5: glyph <= vga_data_in;
               default: ;
            endcase
         end
         if (p) begin
            if ((sub == 4'd15) && fetch_on) begin
               shift <= tgt_line[0] ? glyph[7:0] : glyph[15:8];
               fg    <= attr;
            end else begin
               shift <= {shift[6:0], 1'b0};
            end
         end
      end
   end

`ifdef VGA_TEXT_CURSOR_EN
   logic       frame_tick;
   logic [4:0] frame_cnt;
   logic [6:0] cur_col;
   logic [5:0] cur_row;

   assign frame_tick = (h == 10'd0) && (v == 10'd0) && !p;

   // Blink counter and cursor position, both refreshed once per frame
   always_ff @(posedge ext_clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= 5'd0;
         cur_col   <= 7'd0;
         cur_row   <= 6'd0;
      end else if (!enable) begin
         frame_cnt <= 5'd0;
         cur_col   <= 7'd0;
         cur_row   <= 6'd0;
      end else if (frame_tick) begin
         frame_cnt <= frame_cnt + 5'd1;
         cur_col   <= cursor_col;
         cur_row   <= cursor_row;
      end
   end

   assign pix_bit = shift[7] ^ (frame_cnt[4] && (h[9:3] == cur_col) && (v[8:3] == cur_row));
`else
   assign pix_bit = shift[7];
`endif

   // Colour output, registered from the same state as the syncs
   always_ff @(posedge ext_clk or negedge reset) begin
      if (!reset) begin
         rgb <= 8'd0;
      end else if (!enable) begin
         rgb <= 8'd0;
      end else begin
         rgb <= (visible && pix_bit) ? fg : 8'd0;
      end
   end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer. Horizontal timing is the real 640x480 line;
// the vertical extent is shortened so whole frames fit in a short run.
// A memory model answers vga_addr with one clock of latency; a scoreboard
// queues the expected sync/colour word for each counter state and compares it
// after the DUT's one-clock output latency.
`timescale 1ns/1ps
module tb_vga_text_renderer;

   localparam int V_VIS   = 16;
   localparam int V_FP    = 1;
   localparam int V_SW    = 2;
   localparam int V_BP    = 1;
   localparam int H_TOT   = 800;
   localparam int V_TOT   = V_VIS + V_FP + V_SW + V_BP;
   localparam int FRAME   = 2 * H_TOT * V_TOT;
   localparam int RUN     = FRAME + 3 * 2 * H_TOT;

   logic        ext_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        enable  = 1'b1;
   logic [14:0] vga_addr;
   logic [15:0] vga_data_in;
   logic        hsync;
   logic        vsync;
   logic [7:0]  rgb;
   logic        frame_start;
`ifdef VGA_TEXT_CURSOR_EN
   logic [6:0]  cursor_col = 7'd2;
   logic [5:0]  cursor_row = 6'd0;
`endif

   logic [15:0] mem [0:32767];
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [10:0] outs;
   } exp_t;
   exp_t sb[$];

   vga_text_renderer #(
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
   ) dut (
      .ext_clk    (ext_clk),
      .reset      (reset),
      .enable     (enable),
      .vga_addr   (vga_addr),
      .vga_data_in(vga_data_in),
      .hsync      (hsync),
      .vsync      (vsync),
      .rgb        (rgb),
      .frame_start(frame_start)
`ifdef VGA_TEXT_CURSOR_EN
      ,
      .cursor_col (cursor_col),
      .cursor_row (cursor_row)
`endif
   );

   always #10 ext_clk = ~ext_clk;

   always @(posedge ext_clk) vga_data_in <= mem[vga_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected colour of pixel (x,y) straight from the memory contents
   function automatic logic [7:0] exp_rgb(input int x, input int y, input bit first_frame);
      logic [15:0] w;
      logic [15:0] g;
      logic [7:0]  bits;
      if (x >= 640 || y >= V_VIS) return 8'h00;
      if (first_frame && y == 0 && x < 8) return 8'h00;
      w    = mem[(y / 8) * 128 + x / 8];
      g    = mem[32'h2000 + int'(w[7:0]) * 4 + (y % 8) / 2];
      bits = (y % 2 == 0) ? g[15:8] : g[7:0];
      return bits[7 - x % 8] ? w[15:8] : 8'h00;
   endfunction

   initial begin
      int mh, mv, mp, fr, c;
      int first_fall, hs_low, vs_low, fs_count, fs_first, fs_second;
      int bad_addr, seen_fff;
      logic exp_hs, exp_vs, exp_fs;
      logic [7:0] exp_px;
      logic [7:0] line0_px [0:7];
      logic [7:0] line1_px [0:7];
      exp_t e;

      line0_px = '{8'h00, 8'h00, 8'h00, 8'hE0, 8'hE0, 8'h00, 8'h00, 8'h00};
      line1_px = '{8'h00, 8'h00, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'h00, 8'h00};

      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      for (int i = 0; i < 16'h1000; i++) mem[i] = 16'($urandom);
      for (int i = 16'h2000; i < 16'h2400; i++) mem[i] = 16'($urandom);
      mem[16'h0000] = 16'hE041;
      mem[16'h2104] = 16'h183C;
      mem[16'h0FFF] = 16'h0841;

      // Power-on reset
      #5 reset = 1'b0;
      #1;
      check("por_hsync", 32'(hsync), 32'd1);
      check("por_vsync", 32'(vsync), 32'd1);
      check("por_rgb", 32'(rgb), 32'd0);
      repeat (3) @(negedge ext_clk);
      reset = 1'b1;

      // Run part of a line, then reset in the middle of it
      repeat (500) @(posedge ext_clk);
      @(negedge ext_clk);
      reset = 1'b0;
      #1;
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_rgb", 32'(rgb), 32'd0);
      check("rst_addr", 32'(vga_addr), 32'd0);
      check("rst_fstart", 32'(frame_start), 32'd0);
      repeat (3) @(negedge ext_clk);
      reset = 1'b1;

      mh = 0; mv = 0; mp = 0; fr = 0;
      first_fall = -1; hs_low = 0; vs_low = 0;
      fs_count = 0; fs_first = -1; fs_second = -1;
      bad_addr = 0; seen_fff = 0;

      for (c = 1; c <= RUN; c++) begin
         exp_hs = !(mh >= 656 && mh <= 751);
         exp_vs = !(mv >= V_VIS + V_FP && mv <= V_VIS + V_FP + V_SW - 1);
         exp_fs = (mh == 0 && mv == 0 && mp == 0);
         exp_px = exp_rgb(mh, mv, fr == 0);
         e.outs = {exp_hs, exp_vs, exp_fs, exp_px};
         sb.push_back(e);

         @(posedge ext_clk);
         #1;
         e = sb.pop_front();
         check("scan", 32'({hsync, vsync, frame_start, rgb}), 32'(e.outs));

         if (first_fall < 0 && hsync == 1'b0) first_fall = c;
         if (c <= FRAME && !hsync) hs_low++;
         if (c <= FRAME && !vsync) vs_low++;
         if (frame_start) begin
            fs_count++;
            if (fs_first < 0) fs_first = c;
            else if (fs_second < 0) fs_second = c;
         end
         if (vga_addr < 15'h2000 && vga_addr[6:0] >= 7'd80) bad_addr++;
         if (vga_addr == 15'h0FFF) seen_fff = 1;

         if (mv == 8 && mh == 792 && mp == 0)
            check("pf_text_addr", 32'(vga_addr), 32'h0080);
         if (mv == 8 && mh == 793 && mp == 1)
            check("pf_glyph_addr", 32'(vga_addr), 32'h2000 + 32'(mem[16'h0080][7:0]) * 4);
         if (fr == 1 && mv == 0 && mh < 8 && mp == 0)
            check("line0_px", 32'(rgb), 32'(line0_px[mh]));
         if (fr == 1 && mv == 1 && mh < 8 && mp == 0)
            check("line1_px", 32'(rgb), 32'(line1_px[mh]));

         if (mp == 1) begin
            if (mh == H_TOT - 1) begin
               mh = 0;
               if (mv == V_TOT - 1) begin
                  mv = 0;
                  fr++;
               end else begin
                  mv++;
               end
            end else begin
               mh++;
            end
         end
         mp = 1 - mp;
      end

      check("hs_first_fall", 32'(first_fall), 32'd1313);
      check("hs_low_frame", 32'(hs_low), 32'(192 * V_TOT));
      check("vs_low_frame", 32'(vs_low), 32'(2 * H_TOT * V_SW));
      check("fs_count", 32'(fs_count), 32'd2);
      check("fs_period", 32'(fs_second - fs_first), 32'(FRAME));
      check("addr_range", 32'(bad_addr), 32'd0);
      check("addr_0fff", 32'(seen_fff), 32'd0);

      // Dropping enable returns everything to the reset state on the next clock
      @(negedge ext_clk);
      enable = 1'b0;
      @(posedge ext_clk);
      #1;
      check("en_addr", 32'(vga_addr), 32'd0);
      check("en_rgb", 32'(rgb), 32'd0);
      check("en_hsync", 32'(hsync), 32'd1);
      check("en_fstart", 32'(frame_start), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
